// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer
//   Multi-cycle controller placed in front of a combinational ALU. For each
//   request it clears the accumulator through the ALU (ZERO), then for every
//   incoming operand pair issues MUL (a*b -> prod) followed by ADD
//   (acc + prod -> acc), and reports the final accumulator as the result.
//
// Ports
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   start, len    : request a dot product of len pairs (sampled only in IDLE)
//   op_valid/op_ready, op_a/op_b : operand-pair handshake (row, column element)
//   alu_ctrl, alu_a, alu_b : ALU control code and operands (Moore decodes)
//   alu_c, alu_z  : ALU result and zero flag (combinational from the ALU)
//   busy          : high from the cycle after start is accepted through done
//   done          : one-cycle pulse, result valid
//   result, result_zero : dot product modulo 2^DATA_W and its zero flag
module dot_product_sequencer #(
    parameter int DATA_W = 24,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [2:0]        alu_ctrl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_c,
    input  logic              alu_z,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              result_zero
);

    localparam logic [2:0] ALU_NOP  = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_MUL  = 3'd2;
    localparam logic [2:0] ALU_ZERO = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_OP,
        S_MUL,
        S_ADD,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   a_reg_q, a_reg_d;
    logic [DATA_W-1:0]   b_reg_q, b_reg_d;
    logic [DATA_W-1:0]   prod_q, prod_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0]    len_reg_q, len_reg_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                result_zero_q, result_zero_d;
    logic [LEN_W-1:0]    cnt_inc;

    assign cnt_inc     = cnt_q + LEN_W'(1);
    assign result      = result_q;
    assign result_zero = result_zero_q;

    // Next-state and Moore output decode
    always_comb begin
        state_d       = state_q;
        a_reg_d       = a_reg_q;
        b_reg_d       = b_reg_q;
        prod_d        = prod_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        len_reg_d     = len_reg_q;
        result_d      = result_q;
        result_zero_d = result_zero_q;
        alu_ctrl      = ALU_NOP;
        alu_a         = '0;
        alu_b         = '0;
        op_ready      = 1'b0;
        done          = 1'b0;
        busy          = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_reg_d = len;
                    cnt_d     = '0;
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // The accumulator is cleared through the ALU rather than locally,
                // so the ALU output is also in a known state before the first MUL.
                alu_ctrl = ALU_ZERO;
                acc_d    = alu_c;
                if (len_reg_q == '0) begin
                    result_d      = '0;
                    result_zero_d = 1'b1;
                    state_d       = S_DONE;
                end else begin
                    state_d = S_WAIT_OP;
                end
            end
            S_WAIT_OP: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    a_reg_d = op_a;
                    b_reg_d = op_b;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                alu_ctrl = ALU_MUL;
                alu_a    = a_reg_q;
                alu_b    = b_reg_q;
                prod_d   = alu_c;
                state_d  = S_ADD;
            end
            S_ADD: begin
                alu_ctrl = ALU_ADD;
                alu_a    = acc_q;
                alu_b    = prod_q;
                acc_d    = alu_c;
                cnt_d    = cnt_inc;
                if (cnt_inc == len_reg_q) begin
                    result_d      = alu_c;
                    result_zero_d = alu_z;
                    state_d       = S_DONE;
                end else begin
                    state_d = S_WAIT_OP;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset clears every register so an aborted run leaves no trace
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            a_reg_q       <= '0;
            b_reg_q       <= '0;
            prod_q        <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            len_reg_q     <= '0;
            result_q      <= '0;
            result_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_reg_q       <= a_reg_d;
            b_reg_q       <= b_reg_d;
            prod_q        <= prod_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            len_reg_q     <= len_reg_d;
            result_q      <= result_d;
            result_zero_q <= result_zero_d;
        end
    end

endmodule

// File: doc/dot_product_sequencer.md
Name: dot_product_sequencer

Overview:
- Multi-cycle controller that sits directly in front of the 24-bit ALU.
- Drives the ALU's 3-bit control code and both operands, and captures the ALU result and zero flag.
- Computes the dot product of one matrix row and one column, received as a stream of operand pairs, by sequencing ZERO, then MUL and ADD for each element.
- Feeds the matrix-multiply top level with one 24-bit result per request.

Parameters:
- DATA_W, 24, operand/result width; must match the ALU datapath width.
- LEN_W, 8, width of the vector-length input; maximum length is 2^LEN_W-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request a new dot product; sampled only in IDLE
- len  input  LEN_W  number of element pairs; sampled with start
- op_valid  input  1  op_a/op_b carry a valid pair
- op_ready  output  1  block accepts a pair this cycle
- op_a  input  DATA_W  row element
- op_b  input  DATA_W  column element
- alu_ctrl  output  3  ALU control code
- alu_a  output  DATA_W  ALU operand A
- alu_b  output  DATA_W  ALU operand B
- alu_c  input  DATA_W  ALU result (combinational from alu_ctrl/alu_a/alu_b)
- alu_z  input  1  ALU zero flag
- busy  output  1  high from the cycle after start is accepted until the done cycle inclusive
- done  output  1  one-cycle pulse: result valid
- result  output  DATA_W  dot product modulo 2^DATA_W
- result_zero  output  1  result == 0

Behaviour:
- ALU codes used:
  - NOP = 0: ALU holds its output.
  - ADD = 1
  - MUL = 2
  - ZERO = 6
- alu_ctrl, alu_a and alu_b are registered-state decodes (Moore). alu_c and alu_z are captured on the same clock edge that ends the state driving them.
- State registers: a_reg, b_reg, prod, acc, cnt (LEN_W), len_reg.
- Reset (synchronous, rst high at a clock edge) forces:
  - state = IDLE
  - alu_ctrl = 0, alu_a = 0, alu_b = 0
  - op_ready = 0, busy = 0, done = 0
  - result = 0, result_zero = 0
  - all internal registers = 0
- Reset asserted mid-operation aborts the computation at once. No done is produced, and any pair in flight is discarded.
- States:
  - IDLE:
    - alu_ctrl = NOP, operands 0.
    - If start, latch len into len_reg, clear cnt, go to CLEAR.
  - CLEAR:
    - alu_ctrl = ZERO; acc <= alu_c (0).
    - If len_reg == 0 go to DONE (result <= 0, result_zero <= 1); else go to WAIT_OP.
  - WAIT_OP:
    - op_ready = 1, alu_ctrl = NOP.
    - On op_valid & op_ready: a_reg <= op_a, b_reg <= op_b, go to MUL.
    - Otherwise stay; no timeout.
  - MUL:
    - alu_ctrl = MUL, alu_a = a_reg, alu_b = b_reg.
    - prod <= alu_c.
    - Go to ADD.
  - ADD:
    - alu_ctrl = ADD, alu_a = acc, alu_b = prod.
    - acc <= alu_c; cnt <= cnt+1.
    - If cnt+1 == len_reg: result <= alu_c, result_zero <= alu_z, go to DONE; else go to WAIT_OP.
  - DONE:
    - done = 1, busy = 1, alu_ctrl = NOP.
    - Go to IDLE.
- op_ready is high only in WAIT_OP; a pair is transferred only when op_valid and op_ready are both high.
- Arithmetic:
  - The product is truncated to DATA_W bits by the ALU; the block adds no extra precision.
  - The sum wraps modulo 2^DATA_W.
  - No saturation and no overflow flag.
- Latency: start accepted at edge k, then CLEAR in cycle k+1.
  - With op_valid held high, each element takes 3 cycles (WAIT_OP, MUL, ADD).
  - done is high in cycle k+2+3N. For N=0, done is high in cycle k+2.
- start while busy is ignored; len is not re-sampled.
- result and result_zero hold their values until the next DONE or reset. They are not cleared by start.
- start asserted in the DONE cycle is ignored. A new request requires start in IDLE, so at least one cycle must separate back-to-back requests.

Test Plan:
- len=3, pairs (1,4),(2,5),(3,6), op_valid always high -> done exactly 11 cycles after the start edge, result=32, result_zero=0, op_ready high in exactly 3 cycles.
- len=0, start -> CLEAR then DONE; done 2 cycles after start, result=0, result_zero=1, op_ready never high, alu_ctrl=6 for one cycle.
- len=1, pair (0x001000,0x001000) -> product wraps to 0x000000; result=0, result_zero=1. Then len=2, pairs (0xFFFFFF,1),(1,1) -> result=0x000000 (sum wrap), result_zero=1.
- len=2, op_valid low 5 cycles before each pair -> block waits in WAIT_OP with op_ready high, alu_ctrl=0; result correct; done delayed by exactly 10 cycles.
- rst asserted in the MUL cycle of element 2 of len=4 -> next cycle: busy=0, op_ready=0, alu_ctrl=0, result=0, no done pulse. A following start with len=1, pair (7,3) -> result=21.
- start re-pulsed with len=5 during a len=2 run -> ignored; exactly 2 pairs consumed, a single done pulse, result reflects 2 elements.
